// File: rtl/captura_pkg.sv
// Shared defaults and per-channel FSM state encoding for captura_muestras_iv.
package captura_pkg;

   localparam int N_MUESTRAS = 32;
   localparam int ANCHO      = 12;
   localparam int DEC        = 4;

   typedef enum logic [1:0] {
      LLENANDO = 2'b00,
      LLENO    = 2'b01,
      ESPERA   = 2'b10
   } estado_e;

endpackage

// File: rtl/buffer_muestras.sv
// Sample buffer: one write port, registered read-first read port.
// Only the read register is reset; the storage array keeps its contents.
module buffer_muestras #(
   parameter int N = 32,
   parameter int W = 12
)(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 we_i,
   input  logic [$clog2(N)-1:0] wr_addr_i,
   input  logic [W-1:0]         wr_data_i,
   input  logic [$clog2(N)-1:0] rd_addr_i,
   output logic [W-1:0]         rd_data_o
);

   logic [W-1:0] mem_q [N];
   logic [W-1:0] rd_data_q;

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[wr_addr_i] <= wr_data_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) rd_data_q <= '0;
      else       rd_data_q <= mem_q[rd_addr_i];
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/captura_canal.sv
// One capture channel: fill FSM, write counter, buffer, and the optional
// strobe decimator compiled in only when CAPTURA_DECIMACION_EN is defined.
//   state    | meaning
//   LLENANDO | accepting samples at cnt_q
//   LLENO    | frame complete, other channel complete too
//   ESPERA   | frame complete, waiting for the other channel or release
module captura_canal
   import captura_pkg::*;
#(
   parameter int N     = 32,
   parameter int W     = 12,
   parameter int DEC_P = 4
)(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 en_i,
   input  logic                 valid_i,
   input  logic [W-1:0]         data_i,
   input  logic                 release_i,
   input  logic                 otro_lleno_i,
   input  logic [$clog2(N)-1:0] rd_addr_i,
   output logic [W-1:0]         rd_data_o,
   output logic                 ack_o,
   output logic                 ovr_o
);

   localparam int AW = $clog2(N);

   estado_e       estado_q;
   logic [AW-1:0] cnt_q;
   logic          ack_q;
   logic          ovr_q;
   logic          strobe;
   logic          dec_ok;
   logic          acepta;
   logic [AW-1:0] wr_addr;

   assign strobe = en_i && valid_i;

`ifdef CAPTURA_DECIMACION_EN
   localparam int DW = $clog2(DEC_P);
   logic [DW-1:0] dec_q;

   assign dec_ok = (dec_q == '0);

   always_ff @(posedge clk_i) begin
      if (rst_i)
         dec_q <= '0;
      else if (release_i)
         dec_q <= strobe ? DW'(1) : '0;
      else if (strobe && estado_q == LLENANDO)
         dec_q <= (dec_q == DW'(DEC_P - 1)) ? '0 : dec_q + DW'(1);
   end
`else
   assign dec_ok = 1'b1;
`endif

   // Release restarts the frame, so a coincident strobe lands at address 0.
   assign acepta  = !rst_i && strobe &&
                    (release_i || (estado_q == LLENANDO && dec_ok));
   assign wr_addr = release_i ? '0 : cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         estado_q <= LLENANDO;
         cnt_q    <= '0;
         ack_q    <= 1'b0;
         ovr_q    <= 1'b0;
      end else if (release_i) begin
         estado_q <= LLENANDO;
         ack_q    <= 1'b0;
         cnt_q    <= acepta ? AW'(1) : '0;
      end else begin
         case (estado_q)
            LLENANDO: begin
               if (acepta) begin
                  cnt_q <= cnt_q + AW'(1);
                  if (cnt_q == AW'(N - 1)) begin
                     estado_q <= LLENO;
                     ack_q    <= 1'b1;
                  end
               end
            end
            LLENO: begin
               if (strobe) ovr_q <= 1'b1;
               if (!otro_lleno_i) estado_q <= ESPERA;
            end
            ESPERA: begin
               if (strobe) ovr_q <= 1'b1;
               if (otro_lleno_i) estado_q <= LLENO;
            end
            default: estado_q <= LLENANDO;
         endcase
      end
   end

   buffer_muestras #(.N(N), .W(W)) u_buffer (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .we_i      (acepta),
      .wr_addr_i (wr_addr),
      .wr_data_i (data_i),
      .rd_addr_i (rd_addr_i),
      .rd_data_o (rd_data_o)
   );

   assign ack_o = ack_q;
   assign ovr_o = ovr_q;

endmodule

// File: rtl/captura_muestras_iv.sv
// Dual-channel (current/voltage) frame capture with per-channel frame ack.
// Optional decimation: define CAPTURA_DECIMACION_EN.
module captura_muestras_iv #(
   parameter int N_MUESTRAS = captura_pkg::N_MUESTRAS,
   parameter int ANCHO      = captura_pkg::ANCHO,
   parameter int DEC        = captura_pkg::DEC
)(
   input  logic                          CLK,
   input  logic                          RESET,
   input  logic                          EN,
   input  logic                          VALID_I,
   input  logic [ANCHO-1:0]              DATA_I,
   input  logic                          VALID_V,
   input  logic [ANCHO-1:0]              DATA_V,
   input  logic                          RELEASE,
   input  logic [$clog2(N_MUESTRAS)-1:0] RD_ADDR,
   output logic [ANCHO-1:0]              RD_DATA_I,
   output logic [ANCHO-1:0]              RD_DATA_V,
   output logic                          ACK_CAS_I,
   output logic                          ACK_CAS_V,
   output logic                          OVERRUN
);

   logic ovr_i;
   logic ovr_v;

   captura_canal #(.N(N_MUESTRAS), .W(ANCHO), .DEC_P(DEC)) u_canal_i (
      .clk_i        (CLK),
      .rst_i        (RESET),
      .en_i         (EN),
      .valid_i      (VALID_I),
      .data_i       (DATA_I),
      .release_i    (RELEASE),
      .otro_lleno_i (ACK_CAS_V),
      .rd_addr_i    (RD_ADDR),
      .rd_data_o    (RD_DATA_I),
      .ack_o        (ACK_CAS_I),
      .ovr_o        (ovr_i)
   );

   captura_canal #(.N(N_MUESTRAS), .W(ANCHO), .DEC_P(DEC)) u_canal_v (
      .clk_i        (CLK),
      .rst_i        (RESET),
      .en_i         (EN),
      .valid_i      (VALID_V),
      .data_i       (DATA_V),
      .release_i    (RELEASE),
      .otro_lleno_i (ACK_CAS_I),
      .rd_addr_i    (RD_ADDR),
      .rd_data_o    (RD_DATA_V),
      .ack_o        (ACK_CAS_V),
      .ovr_o        (ovr_v)
   );

   assign OVERRUN = ovr_i | ovr_v;

endmodule
